// File: rtl/pipe_mips32.sv
// ---------------------------------------------------------------------------
// pipe_mips32
// Five-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB) with its own
// 32x32 register file and a unified word-addressed instruction/data memory.
// Execution starts at PC after reset and stops when an HLT instruction
// reaches write-back.
//
// Ports:
//   clk     - single clock, every state update on the rising edge
//   rst     - asynchronous active-high reset (PC, flags, pipeline valids)
//   halted  - high once HLT has retired, held until reset
//
// Reg, Mem, PC, HALTED and TAKEN_BRANCH keep fixed names so that external
// code can preload and inspect them hierarchically.
// ---------------------------------------------------------------------------
module pipe_mips32 #(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU_RR,
    CLS_ALU_RI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_HALT
  } instrClass_t;

  // Architectural state
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // Set once HLT has been decoded; IF stays idle from then on
  logic        r_fetchStop;

  // IF/ID
  logic        r_ifIdValid;
  logic [31:0] r_ifIdIr;
  logic [31:0] r_ifIdNpc;

  // ID/EX
  logic        r_idExValid;
  instrClass_t r_idExCls;
  logic [5:0]  r_idExOp;
  logic [4:0]  r_idExRs;
  logic [4:0]  r_idExRt;
  logic [4:0]  r_idExDest;
  logic        r_idExWrites;
  logic [31:0] r_idExA;
  logic [31:0] r_idExB;
  logic [31:0] r_idExImm;
  logic [31:0] r_idExNpc;

  // EX/MEM
  logic        r_exMemValid;
  logic        r_exMemIsLoad;
  logic        r_exMemIsStore;
  logic        r_exMemIsHalt;
  logic        r_exMemWrites;
  logic [4:0]  r_exMemDest;
  logic [31:0] r_exMemAlu;
  logic [31:0] r_exMemStoreData;

  // MEM/WB
  logic        r_memWbValid;
  logic        r_memWbIsHalt;
  logic        r_memWbWrites;
  logic [4:0]  r_memWbDest;
  logic [31:0] r_memWbResult;

  // Combinational nets
  logic        w_fetchEnable;
  logic [5:0]  w_idOp;
  logic [4:0]  w_idRs;
  logic [4:0]  w_idRt;
  logic [4:0]  w_idRd;
  logic [31:0] w_idImm;
  instrClass_t w_idCls;
  logic [4:0]  w_idDest;
  logic        w_idWrites;
  logic        w_idIsHalt;
  logic [31:0] w_idA;
  logic [31:0] w_idB;
  logic        w_wbWrite;
  logic [31:0] w_exA;
  logic [31:0] w_exB;
  logic [31:0] w_exAlu;
  logic        w_branchTaken;
  logic [31:0] w_branchTarget;
  logic [31:0] w_memResult;

  assign halted = HALTED;

  // ---------------- ID: field extraction and decode ----------------
  assign w_idOp  = r_ifIdIr[31:26];
  assign w_idRs  = r_ifIdIr[25:21];
  assign w_idRt  = r_ifIdIr[20:16];
  assign w_idRd  = r_ifIdIr[15:11];
  assign w_idImm = {{16{r_ifIdIr[15]}}, r_ifIdIr[15:0]};

  always_comb begin
    w_idCls  = CLS_NOP;
    w_idDest = w_idRt;
    case (w_idOp)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        w_idCls  = CLS_ALU_RR;
        w_idDest = w_idRd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: w_idCls = CLS_ALU_RI;
      OP_LW:                     w_idCls = CLS_LOAD;
      OP_SW:                     w_idCls = CLS_STORE;
      OP_BNEQZ, OP_BEQZ:         w_idCls = CLS_BRANCH;
      OP_HLT:                    w_idCls = CLS_HALT;
      default:                   w_idCls = CLS_NOP;
    endcase
  end

  // A destination of R0 is turned into "no write" here, which also keeps
  // R0 out of every forwarding path further down the pipe.
  assign w_idWrites = ((w_idCls == CLS_ALU_RR) || (w_idCls == CLS_ALU_RI) ||
                       (w_idCls == CLS_LOAD)) && (w_idDest != 5'd0);
  assign w_idIsHalt = r_ifIdValid && (w_idCls == CLS_HALT);

  // Register file read with write-through from the instruction in WB
  assign w_wbWrite = r_memWbValid && r_memWbWrites && !HALTED;

  always_comb begin
    w_idA = Reg[w_idRs];
    if (w_wbWrite && (r_memWbDest == w_idRs)) w_idA = r_memWbResult;
    if (w_idRs == 5'd0) w_idA = 32'd0;
    w_idB = Reg[w_idRt];
    if (w_wbWrite && (r_memWbDest == w_idRt)) w_idB = r_memWbResult;
    if (w_idRt == 5'd0) w_idB = 32'd0;
  end

  // ---------------- EX: forwarding, ALU, branch ----------------
  // A load's EX/MEM value is its address, not its data, so loads are never
  // forwarded from EX/MEM; a consumer right behind a LW sees the old value.
  always_comb begin
    w_exA = r_idExA;
    if (r_memWbValid && r_memWbWrites && (r_memWbDest == r_idExRs))
      w_exA = r_memWbResult;
    if (r_exMemValid && r_exMemWrites && !r_exMemIsLoad && (r_exMemDest == r_idExRs))
      w_exA = r_exMemAlu;
    w_exB = r_idExB;
    if (r_memWbValid && r_memWbWrites && (r_memWbDest == r_idExRt))
      w_exB = r_memWbResult;
    if (r_exMemValid && r_exMemWrites && !r_exMemIsLoad && (r_exMemDest == r_idExRt))
      w_exB = r_exMemAlu;
  end

  always_comb begin
    w_exAlu = 32'd0;
    case (r_idExCls)
      CLS_ALU_RR: begin
        case (r_idExOp)
          OP_ADD:  w_exAlu = w_exA + w_exB;
          OP_SUB:  w_exAlu = w_exA - w_exB;
          OP_AND:  w_exAlu = w_exA & w_exB;
          OP_OR:   w_exAlu = w_exA | w_exB;
          OP_SLT:  w_exAlu = {31'd0, ($signed(w_exA) < $signed(w_exB))};
          OP_MUL:  w_exAlu = w_exA * w_exB;
          default: w_exAlu = 32'd0;
        endcase
      end
      CLS_ALU_RI: begin
        case (r_idExOp)
          OP_ADDI: w_exAlu = w_exA + r_idExImm;
          OP_SUBI: w_exAlu = w_exA - r_idExImm;
          OP_SLTI: w_exAlu = {31'd0, ($signed(w_exA) < $signed(r_idExImm))};
          default: w_exAlu = 32'd0;
        endcase
      end
      CLS_LOAD, CLS_STORE: w_exAlu = w_exA + r_idExImm;
      default:             w_exAlu = 32'd0;
    endcase
  end

  assign w_branchTarget = r_idExNpc + r_idExImm;
  assign w_branchTaken  = r_idExValid && (r_idExCls == CLS_BRANCH) &&
                          ((r_idExOp == OP_BEQZ) ? (w_exA == 32'd0) : (w_exA != 32'd0));

  // IF idles once HLT is in ID or has passed it, and during a redirect
  assign w_fetchEnable = !r_fetchStop && !w_idIsHalt && !w_branchTaken;

  // ---------------- MEM: load data select ----------------
  assign w_memResult = r_exMemIsLoad ? Mem[r_exMemAlu[AW-1:0]] : r_exMemAlu;

  // Control state: PC, flags and valid bits. A taken branch redirects PC and
  // squashes the two younger instructions in IF/ID and ID/EX; it also wins
  // over an HLT sitting in ID, so that HLT never sets the fetch stop. Once
  // HALTED is set the whole machine freezes until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      r_fetchStop  <= 1'b0;
      r_ifIdValid  <= 1'b0;
      r_idExValid  <= 1'b0;
      r_exMemValid <= 1'b0;
      r_memWbValid <= 1'b0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= w_branchTaken;
      if (w_branchTaken)
        PC <= w_branchTarget;
      else if (w_fetchEnable)
        PC <= PC + 32'd1;
      r_ifIdValid  <= w_fetchEnable;
      r_idExValid  <= r_ifIdValid && !w_branchTaken;
      r_exMemValid <= r_idExValid;
      r_memWbValid <= r_exMemValid;
      if (w_idIsHalt && !w_branchTaken) r_fetchStop <= 1'b1;
      if (r_memWbValid && r_memWbIsHalt) HALTED <= 1'b1;
    end
  end

  // Pipeline payloads. These carry no reset: their valid bits above decide
  // whether any of it is ever acted upon.
  always_ff @(posedge clk) begin
    if (!HALTED) begin
      if (w_fetchEnable) begin
        r_ifIdIr  <= Mem[PC[AW-1:0]];
        r_ifIdNpc <= PC + 32'd1;
      end
      r_idExCls    <= w_idCls;
      r_idExOp     <= w_idOp;
      r_idExRs     <= w_idRs;
      r_idExRt     <= w_idRt;
      r_idExDest   <= w_idDest;
      r_idExWrites <= w_idWrites;
      r_idExA      <= w_idA;
      r_idExB      <= w_idB;
      r_idExImm    <= w_idImm;
      r_idExNpc    <= r_ifIdNpc;

      r_exMemIsLoad    <= (r_idExCls == CLS_LOAD);
      r_exMemIsStore   <= (r_idExCls == CLS_STORE);
      r_exMemIsHalt    <= (r_idExCls == CLS_HALT);
      r_exMemWrites    <= r_idExWrites;
      r_exMemDest      <= r_idExDest;
      r_exMemAlu       <= w_exAlu;
      r_exMemStoreData <= w_exB;

      r_memWbIsHalt <= r_exMemIsHalt;
      r_memWbWrites <= r_exMemWrites;
      r_memWbDest   <= r_exMemDest;
      r_memWbResult <= w_memResult;
    end
  end

  // Data memory write: SW commits in the MEM stage
  always_ff @(posedge clk) begin
    if (!HALTED && r_exMemValid && r_exMemIsStore)
      Mem[r_exMemAlu[AW-1:0]] <= r_exMemStoreData;
  end

  // Register file write in WB; R0 never appears as a write destination
  always_ff @(posedge clk) begin
    if (w_wbWrite)
      Reg[r_memWbDest] <= r_memWbResult;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// ---------------------------------------------------------------------------
// tb_pipe_mips32
// Directed bench for pipe_mips32: small hand-assembled programs are preloaded
// into Mem (with Reg[k]=k), run until halted, and the resulting register,
// memory and control state is compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pipe_mips32;

  logic clk;
  logic rst;
  logic halted;

  int total;
  int bad;
  int edges;
  int takenCount;
  logic [31:0] prog [$];

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch reports tag/observed/expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold reset, load prog into Mem (rest zeroed), set Reg[k]=k, release
  task automatic applyStimulus();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++)
      dut.Mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    for (int k = 0; k < 32; k++)
      dut.Reg[k] = 32'(k);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One rising edge, then settle to the following falling edge for sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Step until halted or limit edges; counts TAKEN_BRANCH cycles on the way
  task automatic runUntilHalt(input int limit);
    edges = 0;
    takenCount = 0;
    while (!halted && edges < limit) begin
      step();
      edges++;
      if (dut.TAKEN_BRANCH === 1'b1) takenCount++;
    end
  endtask

  // Linear sequence of directed scenarios
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_pc", dut.PC, 32'd0);
    checkOutput("reset_halted", {31'd0, halted}, 32'd0);
    checkOutput("reset_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // Independent ALU ops separated by fillers
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    applyStimulus();
    runUntilHalt(20);
    checkOutput("p1_halted", {31'd0, halted}, 32'd1);
    checkOutput("p1_edges", 32'(edges), 32'd13);
    checkOutput("p1_r0", dut.Reg[0], 32'd0);
    checkOutput("p1_r1", dut.Reg[1], 32'd10);
    checkOutput("p1_r2", dut.Reg[2], 32'd20);
    checkOutput("p1_r3", dut.Reg[3], 32'd25);
    checkOutput("p1_r4", dut.Reg[4], 32'd30);
    checkOutput("p1_r5", dut.Reg[5], 32'd55);
    checkOutput("p1_r7", dut.Reg[7], 32'd7);

    // Same program without fillers: forwarding, exact halt timing
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000, 32'h00832800,
             32'hfc000000};
    applyStimulus();
    repeat (9) step();
    checkOutput("p2_halted_e9", {31'd0, halted}, 32'd0);
    step();
    checkOutput("p2_halted_e10", {31'd0, halted}, 32'd1);
    checkOutput("p2_pc", dut.PC, 32'd6);
    checkOutput("p2_r4", dut.Reg[4], 32'd30);
    checkOutput("p2_r5", dut.Reg[5], 32'd55);

    // Load, use at distance 2, store with EX/MEM-forwarded data
    prog = '{32'h28010078, 32'h20220000, 32'h0ce77800, 32'h2843002d, 32'h24230001,
             32'hfc000000};
    applyStimulus();
    dut.Mem[120] = 32'd85;
    runUntilHalt(20);
    checkOutput("ls_halted", {31'd0, halted}, 32'd1);
    checkOutput("ls_r2", dut.Reg[2], 32'd85);
    checkOutput("ls_r3", dut.Reg[3], 32'd130);
    checkOutput("ls_mem121", dut.Mem[121], 32'd130);

    // BEQZ taken: two younger instructions squashed
    prog = '{32'h28010000, 32'h38200002, 32'h28020007, 32'h28030008, 32'h28040009,
             32'hfc000000};
    applyStimulus();
    runUntilHalt(20);
    checkOutput("beqz_halted", {31'd0, halted}, 32'd1);
    checkOutput("beqz_r2", dut.Reg[2], 32'd2);
    checkOutput("beqz_r3", dut.Reg[3], 32'd3);
    checkOutput("beqz_r4", dut.Reg[4], 32'd9);
    checkOutput("beqz_pulses", 32'(takenCount), 32'd1);

    // BEQZ not taken
    prog = '{32'h28010005, 32'h38200002, 32'h28020007, 32'h28030008, 32'h28040009,
             32'hfc000000};
    applyStimulus();
    runUntilHalt(20);
    checkOutput("beqznt_r2", dut.Reg[2], 32'd7);
    checkOutput("beqznt_r3", dut.Reg[3], 32'd8);
    checkOutput("beqznt_r4", dut.Reg[4], 32'd9);
    checkOutput("beqznt_pulses", 32'(takenCount), 32'd0);

    // BNEQZ taken on a nonzero register
    prog = '{32'h28010005, 32'h34200002, 32'h28020007, 32'h28030008, 32'h28040009,
             32'hfc000000};
    applyStimulus();
    runUntilHalt(20);
    checkOutput("bneqz_r2", dut.Reg[2], 32'd2);
    checkOutput("bneqz_r3", dut.Reg[3], 32'd3);
    checkOutput("bneqz_r4", dut.Reg[4], 32'd9);
    checkOutput("bneqz_pulses", 32'(takenCount), 32'd1);

    // Remaining ALU ops, negative values, R0 write discard, unknown opcode
    prog = '{32'h2801fffd, 32'h28020007, 32'h04221800, 32'h10222000, 32'h14222800,
             32'h08223000, 32'h3047ffff, 32'h2c280002, 32'h28000005, 32'h00004800,
             32'h7c0a0000, 32'hfc000000};
    applyStimulus();
    runUntilHalt(30);
    checkOutput("alu_edges", 32'(edges), 32'd16);
    checkOutput("alu_sub", dut.Reg[3], 32'hfffffff6);
    checkOutput("alu_slt", dut.Reg[4], 32'd1);
    checkOutput("alu_mul", dut.Reg[5], 32'hffffffeb);
    checkOutput("alu_and", dut.Reg[6], 32'd5);
    checkOutput("alu_slti", dut.Reg[7], 32'd0);
    checkOutput("alu_subi", dut.Reg[8], 32'hfffffffb);
    checkOutput("alu_r0", dut.Reg[0], 32'd0);
    checkOutput("alu_r0_fwd", dut.Reg[9], 32'd0);
    checkOutput("alu_nop", dut.Reg[10], 32'd10);

    // HLT followed by ADDI: nothing younger retires, PC frozen
    prog = '{32'hfc000000, 32'h28060063};
    applyStimulus();
    runUntilHalt(20);
    checkOutput("hlt_edges", 32'(edges), 32'd5);
    checkOutput("hlt_pc", dut.PC, 32'd1);
    repeat (3) step();
    checkOutput("hlt_pc_frozen", dut.PC, 32'd1);
    checkOutput("hlt_halted_held", {31'd0, halted}, 32'd1);
    checkOutput("hlt_r6", dut.Reg[6], 32'd6);

    // Mid-cycle asynchronous reset, then restart from Mem[0]
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_pc", dut.PC, 32'd0);
    checkOutput("arst_halted", {31'd0, halted}, 32'd0);
    checkOutput("arst_r6_kept", dut.Reg[6], 32'd6);
    dut.Mem[0] = 32'h28060063;
    dut.Mem[1] = 32'hfc000000;
    @(negedge clk);
    rst = 1'b0;
    runUntilHalt(20);
    checkOutput("restart_halted", {31'd0, halted}, 32'd1);
    checkOutput("restart_r6", dut.Reg[6], 32'd99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
